// File: rtl/cdp_dp_mul_pipe_if.sv
// ---------------------------------------------------------------------------
// cdp_dp_mul_pipe_if
//   Handshake and payload bundle for the CDP multi-lane multiplier pipe.
//   Input side : mul_vld/mul_rdy with per-lane operands and the shift amount
//                that travels with the transaction.
//   Output side: mul_unit_vld/mul_unit_rdy with per-lane results and
//                per-lane saturation flags.
//   modport master : the surrounding datapath (drives operands, consumes results)
//   modport slave  : the multiplier pipe itself
// ---------------------------------------------------------------------------
interface cdp_dp_mul_pipe_if #(
  parameter int pINA_BW = 9,
  parameter int pINB_BW = 16,
  parameter int pOUT_BW = 16,
  parameter int pLANES  = 4
);
  logic                       mul_vld;
  logic                       mul_rdy;
  logic [pLANES*pINA_BW-1:0]  mul_ina_pd;
  logic [pLANES*pINB_BW-1:0]  mul_inb_pd;
  logic [4:0]                 cfg_shift;
  logic                       mul_unit_vld;
  logic                       mul_unit_rdy;
  logic [pLANES*pOUT_BW-1:0]  mul_unit_pd;
  logic [pLANES-1:0]          mul_unit_sat;

  modport master (
    output mul_vld, mul_ina_pd, mul_inb_pd, cfg_shift, mul_unit_rdy,
    input  mul_rdy, mul_unit_vld, mul_unit_pd, mul_unit_sat
  );

  modport slave (
    input  mul_vld, mul_ina_pd, mul_inb_pd, cfg_shift, mul_unit_rdy,
    output mul_rdy, mul_unit_vld, mul_unit_pd, mul_unit_sat
  );
endinterface

// File: rtl/cdp_dp_mul_pipe.sv
// ---------------------------------------------------------------------------
// cdp_dp_mul_pipe
//   Multi-lane signed multiplier for the CDP datapath. Each lane computes
//   A*B at full width, then applies a round-half-up arithmetic right shift
//   and signed saturation to pOUT_BW bits. pSTAGES register stages sit
//   between accept and output with a stall-correct valid/ready chain.
//
// Ports
//   nvdla_core_clk : core clock
//   nvdla_core_rst : asynchronous reset, active-high
//   mul_if         : slave side of the handshake/payload bundle
//   cfg_sat_clr    : single-cycle pulse, clears sat_cnt (wins over increment)
//   sat_cnt        : saturating count of output transfers with any lane saturated
// ---------------------------------------------------------------------------
module cdp_dp_mul_pipe #(
  parameter int pINA_BW = 9,
  parameter int pINB_BW = 16,
  parameter int pOUT_BW = 16,
  parameter int pLANES  = 4,
  parameter int pSTAGES = 2
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rst,
  cdp_dp_mul_pipe_if.slave       mul_if,
  input  logic                   cfg_sat_clr,
  output logic [31:0]            sat_cnt
);

  localparam int PW   = pINA_BW + pINB_BW;  // full product width
  localparam int RW   = PW + 33;            // headroom for any 2^(shift-1) addend
  localparam int LAST = pSTAGES - 1;

  localparam logic signed [RW-1:0] SAT_MAX = RW'((64'sd1 <<< (pOUT_BW - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  typedef struct packed {
    logic               sat;
    logic [pOUT_BW-1:0] val;
  } lane_res_t;

  // Round-half-up shift followed by signed saturation. The wide intermediate
  // keeps the rounding addend from overflowing for every legal shift.
  function automatic lane_res_t round_sat(input logic signed [PW-1:0] p,
                                          input logic [4:0]           sh);
    logic signed [RW-1:0] r;
    logic signed [RW-1:0] rnd;
    lane_res_t            res;
    r   = RW'(p);
    rnd = '0;
    if (sh != 5'd0) begin
      rnd[sh - 5'd1] = 1'b1;
      r = (r + rnd) >>> sh;
    end
    if (r > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = SAT_MAX[pOUT_BW-1:0];
    end else if (r < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = SAT_MIN[pOUT_BW-1:0];
    end else begin
      res.sat = 1'b0;
      res.val = r[pOUT_BW-1:0];
    end
    return res;
  endfunction

  // -------------------------------------------------------------------------
  // Valid/ready chain. A stage loads when it is empty or its contents leave
  // this cycle, so ld[k] is low only when stage k and every stage after it
  // are full and the output is stalled.
  // -------------------------------------------------------------------------
  logic [pSTAGES-1:0] vld;
  logic [pSTAGES-1:0] vin;   // valid presented to each stage's input
  logic [pSTAGES-1:0] ld;

  always_comb begin : handshake
    logic run_full;
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default is how unintended latches appear.
    run_full = 1'b1;
    ld       = '0;
    vin      = '0;
    vin[0]   = mul_if.mul_vld;
    for (int k = 1; k < pSTAGES; k++) begin
      vin[k] = vld[k-1];
    end
    for (int k = LAST; k >= 0; k--) begin
      run_full = run_full & vld[k];
      ld[k]    = ~run_full | mul_if.mul_unit_rdy;
    end
  end

  assign mul_if.mul_rdy      = ld[0];
  assign mul_if.mul_unit_vld = vld[LAST];

  // A stage valid only changes when the stage loads: it takes the upstream
  // valid, so it clears when data leaves with nothing arriving behind it.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (nvdla_core_rst) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < pSTAGES; k++) begin
        if (ld[k]) vld[k] <= vin[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-lane full-width products.
  // -------------------------------------------------------------------------
  logic [pLANES*PW-1:0] prod_w;

  always_comb begin
    logic signed [pINA_BW-1:0] a;
    logic signed [pINB_BW-1:0] b;
    logic signed [PW-1:0]      p;
    prod_w = '0;
    for (int i = 0; i < pLANES; i++) begin
      a = mul_if.mul_ina_pd[i*pINA_BW +: pINA_BW];
      b = mul_if.mul_inb_pd[i*pINB_BW +: pINB_BW];
      p = PW'(a) * PW'(b);
      prod_w[i*PW +: PW] = p;
    end
  end

  // Source of the final round/saturate stage: straight from the inputs for a
  // single-stage pipe, otherwise from the product/shift delay line.
  logic [pLANES*PW-1:0] src_p;
  logic [4:0]           src_sh;

  generate
    if (pSTAGES == 1) begin : g_single
      assign src_p  = prod_w;
      assign src_sh = mul_if.cfg_shift;
    end else begin : g_multi
      logic [pLANES*PW-1:0] p_q  [pSTAGES-1];
      logic [4:0]           sh_q [pSTAGES-1];

      // Stage 1 captures products and the shift; later entries are pure delay.
      always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
          // NOTE: payload registers are reset too, so the output bus reads zero
          // after reset instead of leftover data.
          for (int k = 0; k < pSTAGES - 1; k++) begin
            p_q[k]  <= '0;
            sh_q[k] <= '0;
          end
        end else begin
          if (ld[0] & vin[0]) begin
            p_q[0]  <= prod_w;
            sh_q[0] <= mul_if.cfg_shift;
          end
          for (int k = 1; k < pSTAGES - 1; k++) begin
            if (ld[k] & vin[k]) begin
              p_q[k]  <= p_q[k-1];
              sh_q[k] <= sh_q[k-1];
            end
          end
        end
      end

      assign src_p  = p_q[pSTAGES-2];
      assign src_sh = sh_q[pSTAGES-2];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Final stage: rounded/saturated lanes and flags.
  // -------------------------------------------------------------------------
  logic [pLANES*pOUT_BW-1:0] res_pd_d;
  logic [pLANES-1:0]         res_sat_d;
  logic [pLANES*pOUT_BW-1:0] res_pd_q;
  logic [pLANES-1:0]         res_sat_q;

  always_comb begin
    lane_res_t lr;
    res_pd_d  = '0;
    res_sat_d = '0;
    for (int i = 0; i < pLANES; i++) begin
      lr = round_sat(src_p[i*PW +: PW], src_sh);
      res_pd_d[i*pOUT_BW +: pOUT_BW] = lr.val;
      res_sat_d[i]                   = lr.sat;
    end
  end

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      res_pd_q  <= '0;
      res_sat_q <= '0;
    end else if (ld[LAST] & vin[LAST]) begin
      res_pd_q  <= res_pd_d;
      res_sat_q <= res_sat_d;
    end
  end

  assign mul_if.mul_unit_pd  = res_pd_q;
  assign mul_if.mul_unit_sat = res_sat_q;

  // -------------------------------------------------------------------------
  // Saturation event counter: one count per transfer with any lane clipped,
  // sticks at all-ones, clear wins over a same-cycle increment.
  // -------------------------------------------------------------------------
  logic out_xfer;
  assign out_xfer = mul_if.mul_unit_vld & mul_if.mul_unit_rdy;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      sat_cnt <= '0;
    end else if (cfg_sat_clr) begin
      sat_cnt <= '0;
    end else if (out_xfer && (|res_sat_q) && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_cdp_dp_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_cdp_dp_mul_pipe
//   Directed bench for cdp_dp_mul_pipe with default parameters. Expected lane
//   results are computed from integer arithmetic when a transaction is
//   accepted, queued, and compared when the pipe transfers it out.
// ---------------------------------------------------------------------------
module tb_cdp_dp_mul_pipe;

  localparam int A = 9;
  localparam int B = 16;
  localparam int O = 16;
  localparam int L = 4;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_sat_clr;
  logic [31:0] sat_cnt;

  cdp_dp_mul_pipe_if #(.pINA_BW(A), .pINB_BW(B), .pOUT_BW(O), .pLANES(L)) mif ();

  cdp_dp_mul_pipe #(
    .pINA_BW(A), .pINB_BW(B), .pOUT_BW(O), .pLANES(L), .pSTAGES(S)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .mul_if         (mif),
    .cfg_sat_clr    (cfg_sat_clr),
    .sat_cnt        (sat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*O-1:0] pd;
    logic [L-1:0]   sat;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   errors    = 0;
  int   sat_model = 0;   // expected sat_cnt once all queued entries drain
  int   n_out     = 0;
  int   inflight;
  logic stream_chk = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Occupancy reference: accepts in, transfers out.
  always @(posedge clk or posedge rst) begin
    if (rst) inflight <= 0;
    else inflight <= inflight + ((mif.mul_vld && mif.mul_rdy) ? 1 : 0)
                              - ((mif.mul_unit_vld && mif.mul_unit_rdy) ? 1 : 0);
  end

  // Output monitor: scoreboard compare on transfer, hold check while stalled.
  exp_t prev;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_vld", 64'(mif.mul_unit_vld), 64'd1);
        check("stall_hold_pd",  mif.mul_unit_pd,  prev.pd);
        check("stall_hold_sat", 64'(mif.mul_unit_sat), 64'(prev.sat));
      end
      if (stream_chk)
        check("rdy_only_when_full", 64'(mif.mul_rdy),
              64'(!(inflight == S && !mif.mul_unit_rdy)));
      if (mif.mul_unit_vld && mif.mul_unit_rdy) begin
        check("out_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("lane_pd",  mif.mul_unit_pd, e.pd);
          check("lane_sat", 64'(mif.mul_unit_sat), 64'(e.sat));
          n_out <= n_out + 1;
        end
      end
      prev_stall <= mif.mul_unit_vld && !mif.mul_unit_rdy;
      prev       <= '{pd: mif.mul_unit_pd, sat: mif.mul_unit_sat};
    end
  end

  // Drive one transaction, wait (bounded) for accept, queue its expectation.
  task automatic send(input int a[L], input int b[L], input int sh);
    exp_t   e;
    longint p, r, mx, mn;
    bit     ok;
    mx = (longint'(1) <<< (O - 1)) - 1;
    mn = -(longint'(1) <<< (O - 1));
    for (int i = 0; i < L; i++) begin
      mif.mul_ina_pd[i*A +: A] = a[i][A-1:0];
      mif.mul_inb_pd[i*B +: B] = b[i][B-1:0];
      p = longint'(a[i]) * longint'(b[i]);
      if (sh == 0) r = p;
      else         r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
      if (r > mx)      begin e.pd[i*O +: O] = mx[O-1:0]; e.sat[i] = 1'b1; end
      else if (r < mn) begin e.pd[i*O +: O] = mn[O-1:0]; e.sat[i] = 1'b1; end
      else             begin e.pd[i*O +: O] = r[O-1:0];  e.sat[i] = 1'b0; end
    end
    mif.cfg_shift = sh[4:0];
    mif.mul_vld   = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = mif.mul_rdy;
      @(posedge clk);
    end
    check("accept", 64'(ok), 64'd1);
    if (ok) begin
      sb.push_back(e);
      if (|e.sat) sat_model++;
    end
    #1 mif.mul_vld = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = (sb.size() == 0) && !mif.mul_unit_vld;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n_before;
    int pat[4];
    bit seen;
    pat = '{1, 0, 0, 1};

    rst              = 1'b1;
    cfg_sat_clr      = 1'b0;
    mif.mul_vld      = 1'b0;
    mif.mul_ina_pd   = '0;
    mif.mul_inb_pd   = '0;
    mif.cfg_shift    = '0;
    mif.mul_unit_rdy = 1'b1;

    // Reset state
    #3;
    check("rst_vld", 64'(mif.mul_unit_vld), 64'd0);
    check("rst_pd",  mif.mul_unit_pd, 64'd0);
    check("rst_sat", 64'(mif.mul_unit_sat), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rdy_after_release", 64'(mif.mul_rdy), 64'd1);
    @(posedge clk); #1;

    // Basic rounding and latency: 3*5>>1 -> 8, -3*5>>1 -> -7
    send('{3, -3, 7, -100}, '{5, 5, -9, 100}, 1);
    @(negedge clk); check("latency_c1", 64'(mif.mul_unit_vld), 64'd0);
    @(negedge clk); check("latency_c2", 64'(mif.mul_unit_vld), 64'd1);
    drain();
    check("sat_cnt_basic", 64'(sat_cnt), 64'(sat_model));

    // Positive overflow at shift 0, then the same product scaled into range
    send('{-256, 0, 0, 0}, '{-32768, 0, 0, 0}, 0);
    drain();
    check("sat_cnt_pos_sat", 64'(sat_cnt), 64'd1);
    send('{-256, 0, 0, 0}, '{-32768, 0, 0, 0}, 9);
    drain();
    check("sat_cnt_no_sat", 64'(sat_cnt), 64'd1);

    // Max and min clipping back-to-back
    send('{255, 0, 0, 0}, '{32767, 0, 0, 0}, 0);
    send('{-256, 0, 0, 0}, '{32767, 0, 0, 0}, 0);
    drain();
    check("sat_cnt_clip", 64'(sat_cnt), 64'd3);

    // Shift travels with its transaction: 256 then 16
    send('{16, 16, 16, 16}, '{16, 16, 16, 16}, 0);
    send('{16, 16, 16, 16}, '{16, 16, 16, 16}, 4);
    drain();

    // Stream of 10 with downstream ready pattern 1,0,0,1
    n_before   = n_out;
    stream_chk = 1'b1;
    fork
      begin
        for (int j = 0; j < 10; j++)
          send('{j + 1, -j, 20 * j, j - 128}, '{100, 300, -7, 257}, j % 3);
      end
      begin
        for (int k = 0; k < 48; k++) begin
          @(posedge clk);
          #1 mif.mul_unit_rdy = pat[k % 4][0];
        end
      end
    join
    stream_chk       = 1'b0;
    mif.mul_unit_rdy = 1'b1;
    drain();
    check("stream_count", 64'(n_out - n_before), 64'd10);
    check("sat_cnt_stream", 64'(sat_cnt), 64'(sat_model));

    // Reset with two transactions held in the stalled pipe
    mif.mul_unit_rdy = 1'b0;
    send('{1, 1, 1, 1}, '{2, 2, 2, 2}, 0);
    send('{2, 2, 2, 2}, '{3, 3, 3, 3}, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_vld", 64'(mif.mul_unit_vld), 64'd0);
    check("midrst_pd",  mif.mul_unit_pd, 64'd0);
    check("midrst_sat_cnt", 64'(sat_cnt), 64'd0);
    sb.delete();
    sat_model = 0;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mif.mul_unit_rdy = 1'b1;
    @(negedge clk);
    check("midrst_rdy", 64'(mif.mul_rdy), 64'd1);
    check("midrst_no_stale1", 64'(mif.mul_unit_vld), 64'd0);
    @(negedge clk);
    check("midrst_no_stale2", 64'(mif.mul_unit_vld), 64'd0);
    @(posedge clk); #1;

    // Clear coincident with a saturating transfer
    send('{255, 0, 0, 0}, '{32767, 0, 0, 0}, 0);
    drain();
    check("sat_cnt_before_clr", 64'(sat_cnt), 64'd1);
    mif.mul_unit_rdy = 1'b0;
    send('{-256, 0, 0, 0}, '{32767, 0, 0, 0}, 0);
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = mif.mul_unit_vld;
    end
    check("clr_wait_vld", 64'(seen), 64'd1);
    @(posedge clk);
    #1 mif.mul_unit_rdy = 1'b1;
    cfg_sat_clr = 1'b1;
    @(posedge clk);
    #1 cfg_sat_clr = 1'b0;
    sat_model = 0;
    @(negedge clk);
    check("sat_cnt_clr_wins", 64'(sat_cnt), 64'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
